// File: rtl/vpg_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vpg_pkg
// Purpose : Shared constants for the video pattern generator: pattern codes,
//           overlay box size and the colour-bar palette helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package vpg_pkg;

  localparam logic [2:0] PAT_BARS  = 3'd0;
  localparam logic [2:0] PAT_GRAD  = 3'd1;
  localparam logic [2:0] PAT_CHECK = 3'd2;
  localparam logic [2:0] PAT_GRID  = 3'd3;
  localparam logic [2:0] PAT_SOLID = 3'd4;

  localparam int BOX_SZ = 32;

  // Bar index to {R,G,B}. Inverting index bits gives the classic order
  // white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
    return {{8{~idx[1]}}, {8{~idx[2]}}, {8{~idx[0]}}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/vpg_timing.sv
`default_nettype none
// ============================================================================
// Module  : vpg_timing
// Purpose : Raster counters and sync/active decode for the pattern generator.
// Ports   : clk, rst (async, active-low), i_en (advance enable)
//           o_h_cnt / o_v_cnt   - current raster position
//           o_frame_start       - position is (0,0)
//           o_line_end          - last pixel of a line
//           o_frame_end         - last pixel of the frame
//           o_dv / o_hs / o_vs  - combinational decode of the position
// Revision: 1.0 - initial release
// ============================================================================
module vpg_timing
  import vpg_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter int HW       = 11,
  parameter int VW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  output logic [HW-1:0] o_h_cnt,
  output logic [VW-1:0] o_v_cnt,
  output logic          o_frame_start,
  output logic          o_line_end,
  output logic          o_frame_end,
  output logic          o_dv,
  output logic          o_hs,
  output logic          o_vs
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [HW-1:0] C_H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] C_H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] C_HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] C_HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] C_V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] C_V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] C_VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] C_VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  logic          w_line_end;
  logic          w_frame_end;

  assign w_line_end  = (r_h_cnt == C_H_LAST);
  assign w_frame_end = w_line_end && (r_v_cnt == C_V_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (i_en) begin
      if (w_line_end) begin
        r_h_cnt <= '0;
        r_v_cnt <= (r_v_cnt == C_V_LAST) ? '0 : r_v_cnt + VW'(1);
      end else begin
        r_h_cnt <= r_h_cnt + HW'(1);
      end
    end
  end

  assign o_h_cnt       = r_h_cnt;
  assign o_v_cnt       = r_v_cnt;
  assign o_frame_start = (r_h_cnt == '0) && (r_v_cnt == '0);
  assign o_line_end    = w_line_end;
  assign o_frame_end   = w_frame_end;
  assign o_dv          = (r_h_cnt < C_H_ACT) && (r_v_cnt < C_V_ACT);
  assign o_hs          = (r_h_cnt >= C_HS_BEG) && (r_h_cnt < C_HS_END);
  assign o_vs          = (r_v_cnt >= C_VS_BEG) && (r_v_cnt < C_VS_END);

endmodule
`default_nettype wire

// File: rtl/video_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module  : video_pattern_gen
// Purpose : Synthetic video source: raster timing plus 8-bit RGB test
//           patterns, one-cycle registered output.
// Ports   : clk, rst (async, active-low), en (advance enable)
//           sw[2:0] pattern select, sw[7:3] solid grey level
//           tx_red/tx_green/tx_blue, tx_dv, tx_hs, tx_vs - video stream
// Options : VPG_MOVING_BOX_EN - overlay a 32x32 white box that moves each
//           frame on patterns 0-4.
// Revision: 1.0 - initial release
// ============================================================================
module video_pattern_gen
  import vpg_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] sw,
  output logic [7:0] tx_red,
  output logic [7:0] tx_green,
  output logic [7:0] tx_blue,
  output logic       tx_dv,
  output logic       tx_hs,
  output logic       tx_vs
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int PW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [PW-1:0] C_BAR_LAST = PW'(BAR_W - 1);

  logic [HW-1:0] w_h_cnt;
  logic [VW-1:0] w_v_cnt;
  logic          w_frame_start;
  logic          w_line_end;
  logic          w_frame_end;
  logic          w_dv;
  logic          w_hs;
  logic          w_vs;

  vpg_timing #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .HW       (HW),       .VW   (VW)
  ) u_timing (
    .clk           (clk),
    .rst           (rst),
    .i_en          (en),
    .o_h_cnt       (w_h_cnt),
    .o_v_cnt       (w_v_cnt),
    .o_frame_start (w_frame_start),
    .o_line_end    (w_line_end),
    .o_frame_end   (w_frame_end),
    .o_dv          (w_dv),
    .o_hs          (w_hs),
    .o_vs          (w_vs)
  );

  // ---------------------------------------------------------------- pattern
  logic [2:0] r_pat_sel;
  logic [4:0] r_level;
  logic [2:0] w_pat;
  logic [4:0] w_level;

  // At (0,0) the latch is being loaded this very cycle, so the first pixel
  // of the frame must already use the fresh switch value.
  assign w_pat   = w_frame_start ? sw[2:0] : r_pat_sel;
  assign w_level = w_frame_start ? sw[7:3] : r_level;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pat_sel <= '0;
      r_level   <= '0;
    end else if (en && w_frame_start) begin
      r_pat_sel <= sw[2:0];
      r_level   <= sw[7:3];
    end
  end

  // Running bar counter tracks h_cnt so bar index needs no divider; the
  // index saturates at 7 to absorb any H_ACTIVE remainder.
  logic [PW-1:0] r_bar_px;
  logic [2:0]    r_bar_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bar_px  <= '0;
      r_bar_idx <= '0;
    end else if (en) begin
      if (w_line_end) begin
        r_bar_px  <= '0;
        r_bar_idx <= '0;
      end else if (r_bar_px == C_BAR_LAST) begin
        r_bar_px  <= '0;
        r_bar_idx <= (r_bar_idx == 3'd7) ? 3'd7 : r_bar_idx + 3'd1;
      end else begin
        r_bar_px  <= r_bar_px + PW'(1);
      end
    end
  end

  logic [7:0] w_x_lo8;
  logic       w_y_b5;
  logic [3:0] w_y_lo4;
  logic [23:0] w_pix;
  logic [23:0] w_rgb;

  assign w_x_lo8 = 8'(w_h_cnt);
  assign w_y_b5  = 1'(w_v_cnt >> 5);
  assign w_y_lo4 = 4'(w_v_cnt);

  always_comb begin
    w_pix = '0;
    case (w_pat)
      PAT_BARS:  w_pix = bar_rgb(r_bar_idx);
      PAT_GRAD:  w_pix = {3{w_x_lo8}};
      PAT_CHECK: w_pix = {24{w_x_lo8[5] ^ w_y_b5}};
      PAT_GRID:  w_pix = {24{(w_x_lo8[3:0] == 4'd0) || (w_y_lo4 == 4'd0)}};
      PAT_SOLID: w_pix = {3{w_level, 3'b000}};
      default:   w_pix = '0;
    endcase
  end

`ifdef VPG_MOVING_BOX_EN
  localparam logic [HW-1:0] C_BX_MAX = HW'(H_ACTIVE - BOX_SZ);
  localparam logic [VW-1:0] C_BY_MAX = VW'(V_ACTIVE - BOX_SZ);

  logic [HW-1:0] r_bx;
  logic [VW-1:0] r_by;
  logic [HW-1:0] w_bx_nxt;
  logic [VW-1:0] w_by_nxt;
  logic          w_in_box;

  assign w_bx_nxt = r_bx + HW'(4);
  assign w_by_nxt = r_by + VW'(2);

  // Position moves on the wrap into (0,0) so the whole new frame, including
  // its first pixel, sees the new position.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bx <= '0;
      r_by <= '0;
    end else if (en && w_frame_end) begin
      r_bx <= (w_bx_nxt > C_BX_MAX) ? '0 : w_bx_nxt;
      r_by <= (w_by_nxt > C_BY_MAX) ? '0 : w_by_nxt;
    end
  end

  assign w_in_box = (w_h_cnt >= r_bx) && (w_h_cnt < r_bx + HW'(BOX_SZ)) &&
                    (w_v_cnt >= r_by) && (w_v_cnt < r_by + VW'(BOX_SZ));
  assign w_rgb    = (w_in_box && (w_pat <= PAT_SOLID)) ? 24'hFFFFFF : w_pix;
`else
  assign w_rgb    = w_pix;
`endif

  // ---------------------------------------------------------------- outputs
  logic [23:0] r_rgb;
  logic        r_dv;
  logic        r_hs;
  logic        r_vs;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rgb <= '0;
      r_dv  <= 1'b0;
      r_hs  <= 1'b0;
      r_vs  <= 1'b0;
    end else if (en) begin
      r_rgb <= w_dv ? w_rgb : 24'h0;
      r_dv  <= w_dv;
      r_hs  <= w_hs;
      r_vs  <= w_vs;
    end
  end

  assign tx_red   = r_rgb[23:16];
  assign tx_green = r_rgb[15:8];
  assign tx_blue  = r_rgb[7:0];
  assign tx_dv    = r_dv;
  assign tx_hs    = r_hs;
  assign tx_vs    = r_vs;

endmodule
`default_nettype wire
